// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and requester id type for the round-robin ALU arbiter.
// Optional divide-by-zero flag port is enabled with ALU_RR_ARBITER_DIVZERO_FLAG_EN.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_MOD = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    typedef logic req_id_t;

    function automatic logic is_div_zero(input logic [2:0] sel, input logic y_zero);
        return ((sel == ALU_DIV) || (sel == ALU_MOD)) && y_zero;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational N-bit ALU with a 2N-bit result; division and modulo by zero
// return defined values (all-ones and zero-extended x) instead of X.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    input  logic [2:0]     sel,
    output logic [2*N-1:0] result
);

    logic [2*N-1:0] xe;
    logic [2*N-1:0] ye;
    logic           y_zero;

    assign xe     = {{N{1'b0}}, x};
    assign ye     = {{N{1'b0}}, y};
    assign y_zero = (y == '0);

    always_comb begin
        result = '0;
        case (sel)
            ALU_ADD: result = xe + ye;
            ALU_SUB: result = xe - ye;
            ALU_MUL: result = xe * ye;
            ALU_DIV: result = y_zero ? '1 : xe / ye;
            ALU_XOR: result = xe ^ ye;
            ALU_MOD: result = y_zero ? xe : xe % ye;
            ALU_SHL: result = xe << 1;
            ALU_SHR: result = xe >> 1;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for one shared ALU: IDLE grants, EXEC computes,
// RESP holds the tagged result until consumed. ALU_RR_ARBITER_DIVZERO_FLAG_EN adds rsp_err.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_x,
    input  logic [N-1:0]   req0_y,
    input  logic [2:0]     req0_sel,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_x,
    input  logic [N-1:0]   req1_y,
    input  logic [2:0]     req1_sel,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*N-1:0] rsp_data
`ifdef ALU_RR_ARBITER_DIVZERO_FLAG_EN
    ,
    output logic           rsp_err
`endif
);

    state_e         state_q,    state_d;
    logic [N-1:0]   op_x_q,     op_x_d;
    logic [N-1:0]   op_y_q,     op_y_d;
    logic [2:0]     op_sel_q,   op_sel_d;
    req_id_t        op_id_q,    op_id_d;
    req_id_t        last_q,     last_d;
    logic           rsp_valid_q, rsp_valid_d;
    req_id_t        rsp_id_q,   rsp_id_d;
    logic [2*N-1:0] rsp_data_q, rsp_data_d;
`ifdef ALU_RR_ARBITER_DIVZERO_FLAG_EN
    logic           rsp_err_q,  rsp_err_d;
`endif

    logic           grant_valid;
    req_id_t        grant_id;
    logic [2*N-1:0] alu_result;

    alu_core #(.N(N)) u_alu_core (
        .x      (op_x_q),
        .y      (op_y_q),
        .sel    (op_sel_q),
        .result (alu_result)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        op_x_d      = op_x_q;
        op_y_d      = op_y_q;
        op_sel_d    = op_sel_q;
        op_id_d     = op_id_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
`ifdef ALU_RR_ARBITER_DIVZERO_FLAG_EN
        rsp_err_d   = rsp_err_q;
`endif
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;

        // On a tie the requester that did not win last time gets the ALU.
        grant_valid = req0_valid | req1_valid;
        grant_id    = (req0_valid && req1_valid) ? !last_q : !req0_valid;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    // NOTE: ready is masked during reset so nothing looks accepted while the flops are being cleared.
                    req0_ready = rst_n && (grant_id == 1'b0);
                    req1_ready = rst_n && (grant_id == 1'b1);
                    op_x_d     = grant_id ? req1_x   : req0_x;
                    op_y_d     = grant_id ? req1_y   : req0_y;
                    op_sel_d   = grant_id ? req1_sel : req0_sel;
                    op_id_d    = grant_id;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_result;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
`ifdef ALU_RR_ARBITER_DIVZERO_FLAG_EN
                rsp_err_d   = is_div_zero(op_sel_q, op_y_q == '0);
`endif
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    last_d      = rsp_id_q;
`ifdef ALU_RR_ARBITER_DIVZERO_FLAG_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_x_q      <= '0;
            op_y_q      <= '0;
            op_sel_q    <= '0;
            op_id_q     <= 1'b0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
`ifdef ALU_RR_ARBITER_DIVZERO_FLAG_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_x_q      <= op_x_d;
            op_y_q      <= op_y_d;
            op_sel_q    <= op_sel_d;
            op_id_q     <= op_id_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
`ifdef ALU_RR_ARBITER_DIVZERO_FLAG_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
`ifdef ALU_RR_ARBITER_DIVZERO_FLAG_EN
    assign rsp_err   = rsp_err_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: directed commands push expected responses,
// an independent monitor models the grant order and compares every response.
`timescale 1ns/1ps
module tb_alu_rr_arbiter;
    import alu_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0]   req0_x, req0_y, req1_x, req1_y;
    logic [2:0]     req0_sel, req1_sel;
    logic           rsp_valid, rsp_ready, rsp_id;
    logic [2*N-1:0] rsp_data;
`ifdef ALU_RR_ARBITER_DIVZERO_FLAG_EN
    logic           rsp_err;
`endif

    always #5 clk = ~clk;

    alu_rr_arbiter #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_sel   (req1_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data)
`ifdef ALU_RR_ARBITER_DIVZERO_FLAG_EN
        ,
        .rsp_err    (rsp_err)
`endif
    );

    typedef struct {
        logic       id;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] cmd_exp_data [2];
    logic       cmd_exp_err  [2];
    int         n_vec = 0;
    int         n_err = 0;
    int         cycle = 0;
    bit         model_busy = 1'b0;
    logic       model_last = 1'b1;
    int         accept_cycle = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_id = 1'b0;
    logic [7:0] prev_data = '0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: reference grant model plus response scoreboard.
    initial begin
        logic g;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_busy = 1'b0;
                model_last = 1'b1;
                exp_q.delete();
                prev_valid = 1'b0;
            end else begin
                if (prev_valid && !prev_ready) begin
                    check("rsp_hold_valid", rsp_valid, 1);
                    check("rsp_hold_id", rsp_id, prev_id);
                    check("rsp_hold_data", rsp_data, prev_data);
                end
                if (rsp_valid && !prev_valid)
                    check("rsp_latency", cycle - accept_cycle, 2);
                if (model_busy) begin
                    if (req0_valid || req1_valid) begin
                        check("ready0_while_busy", req0_ready, 0);
                        check("ready1_while_busy", req1_ready, 0);
                    end
                end else if (req0_valid || req1_valid) begin
                    g = (req0_valid && req1_valid) ? !model_last : !req0_valid;
                    check("ready0_grant", req0_ready, (g == 1'b0));
                    check("ready1_grant", req1_ready, (g == 1'b1));
                    exp_q.push_back('{id: g, data: cmd_exp_data[g], err: cmd_exp_err[g]});
                    model_busy   = 1'b1;
                    accept_cycle = cycle;
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_rsp: got id=%0d data=0x%0h, expected no response", rsp_id, rsp_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_id", rsp_id, e.id);
                        check("rsp_data", rsp_data, e.data);
`ifdef ALU_RR_ARBITER_DIVZERO_FLAG_EN
                        check("rsp_err", rsp_err, e.err);
`endif
                        model_last = e.id;
                        model_busy = 1'b0;
                    end
                end
                prev_valid = rsp_valid;
                prev_ready = rsp_ready;
                prev_id    = rsp_id;
                prev_data  = rsp_data;
            end
        end
    end

    // Raise a command on requester k, hold it until granted, then drop valid.
    task automatic send(input int k, input logic [3:0] x, input logic [3:0] y,
                        input logic [2:0] sel, input logic [7:0] ed, input logic ee);
        bit granted = 1'b0;
        cmd_exp_data[k] = ed;
        cmd_exp_err[k]  = ee;
        if (k == 0) begin
            req0_x = x; req0_y = y; req0_sel = sel; req0_valid = 1'b1;
        end else begin
            req1_x = x; req1_y = y; req1_sel = sel; req1_valid = 1'b1;
        end
        for (int t = 0; t < 100 && !granted; t++) begin
            @(negedge clk);
            granted = (k == 0) ? req0_ready : req1_ready;
        end
        if (!granted) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: requester %0d got ready=0, expected a grant within 100 cycles", k);
        end
        @(posedge clk);
        #1;
        if (k == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            done = !model_busy && (exp_q.size() == 0);
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_sel = '0;
        req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_sel = '0;
        rsp_ready  = 1'b1;

        // Reset values; a valid request during reset must not be acknowledged.
        repeat (2) @(posedge clk);
        #1 req0_valid = 1'b1;
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_ready0", req0_ready, 0);
        check("reset_ready1", req1_ready, 0);
`ifdef ALU_RR_ARBITER_DIVZERO_FLAG_EN
        check("reset_rsp_err", rsp_err, 0);
`endif
        @(posedge clk);
        #1 req0_valid = 1'b0;
        rst_n = 1'b1;

        // Both requesters held valid: grants alternate 0,1,0,1.
        fork
            begin
                send(0, 4'd3,  4'd5, ALU_ADD, 8'h08, 1'b0);
                send(0, 4'hA,  4'h5, ALU_XOR, 8'h0F, 1'b0);
            end
            begin
                send(1, 4'd3,  4'd5, ALU_SUB, 8'hFE, 1'b0);
                send(1, 4'd9,  4'd0, ALU_SHR, 8'h04, 1'b0);
            end
        join
        wait_drain();

        // Single requester, widest product.
        send(0, 4'd15, 4'd15, ALU_MUL, 8'hE1, 1'b0);
        wait_drain();

        // Backpressure: response held for 5 cycles while req0 waits.
        rsp_ready = 1'b0;
        fork
            send(1, 4'd15, 4'd0, ALU_SHL, 8'h1E, 1'b0);
            begin
                bit seen = 1'b0;
                for (int t = 0; t < 20 && !seen; t++) begin
                    @(negedge clk);
                    seen = rsp_valid;
                end
                check("stall_rsp_seen", seen, 1);
                repeat (5) @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                send(0, 4'd6, 4'd7, ALU_ADD, 8'h0D, 1'b0);
            end
        join
        wait_drain();

        // Divide/mod by zero and their non-zero counterparts.
        send(1, 4'd9,  4'd0, ALU_DIV, 8'hFF, 1'b1);
        send(1, 4'd9,  4'd0, ALU_MOD, 8'h09, 1'b1);
        send(1, 4'd9,  4'd2, ALU_DIV, 8'h04, 1'b0);
        send(1, 4'd9,  4'd2, ALU_MOD, 8'h01, 1'b0);
        send(0, 4'd15, 4'd4, ALU_DIV, 8'h03, 1'b0);
        wait_drain();

        // Reset while in EXEC drops the command; afterwards req0 wins the first tie.
        send(0, 4'd7, 4'd1, ALU_ADD, 8'h08, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_exec_rsp_valid", rsp_valid, 0);
        check("rst_exec_rsp_data", rsp_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_rsp_after_rst", rsp_valid, 0);
        end
        @(posedge clk);
        #1;
        fork
            send(0, 4'd15, 4'd15, ALU_ADD, 8'h1E, 1'b0);
            send(1, 4'd0,  4'd1,  ALU_SUB, 8'hFF, 1'b0);
        join
        wait_drain();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 ns, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
